// File: rtl/mac_pkg.sv
// Shared Ethernet MAC constants, transmit state encoding and the reflected CRC-32 byte step.
package mac_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int unsigned PREAMBLE_LEN  = 7;
  localparam int unsigned MIN_FRAME     = 60;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_PRE,
    TX_SFD,
    TX_DATA,
    TX_PAD,
    TX_FCS,
    TX_IFG
  } tx_state_e;

  // One byte of the LSB-first CRC-32 recurrence.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (((r[0] ^ d[i]) != 1'b0) ? CRC_POLY_REFL : 32'h0);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-parallel reflected CRC-32 register; init wins over en.
module crc32_d8
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc32_byte(crc_q, d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/mac_tx2.sv
// GMII transmit MAC: buffers one frame, then sends preamble, SFD, data, pad, FCS and an IFG.
module mac_tx2
  import mac_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned MAX_LEN   = 1514,
  parameter int unsigned IFG_BYTES = 12
) (
  input  logic              Tx_Clk,
  input  logic              reset,
  input  logic              Wr_en,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [7:0]        Wr_data,
  input  logic              Frm_send,
  input  logic [ADDR_W:0]   Frm_len,
  output logic              Tx_busy,
  output logic              Tx_done,
  output logic [7:0]        PHY_TXD,
  output logic              PHY_TXEN
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [7:0]        txd_q, txd_d;
  logic              txen_q, txen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [7:0]        mem_q [0:DEPTH-1];
  logic [7:0]        rd_data_q;
  logic [ADDR_W-1:0] rd_addr;

  logic              crc_init, crc_en;
  logic [7:0]        crc_din;
  logic [31:0]       crc, fcs;
  logic              accept;
  logic [CNT_W-1:0]  clamped_len;

  crc32_d8 u_crc (
    .clk   (Tx_Clk),
    .reset (reset),
    .init  (crc_init),
    .en    (crc_en),
    .d     (crc_din),
    .crc   (crc)
  );

  assign fcs         = ~crc;
  assign accept      = Frm_send && (Frm_len != '0);
  assign clamped_len = (Frm_len > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : Frm_len;

  // Frame buffer: writes only while idle; the read address runs one byte ahead of DATA.
  always_ff @(posedge Tx_Clk) begin
    if (Wr_en && !busy_q) begin
      mem_q[Wr_Addr] <= Wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    txd_d    = 8'h00;
    txen_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    crc_din  = 8'h00;
    rd_addr  = '0;
    case (state_q)
      TX_IDLE: begin
        if (accept) begin
          state_d = TX_PRE;
          cnt_d   = '0;
          len_d   = clamped_len;
          busy_d  = 1'b1;
        end
      end
      TX_PRE: begin
        txen_d = 1'b1;
        txd_d  = PREAMBLE_BYTE;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
          state_d = TX_SFD;
        end
      end
      TX_SFD: begin
        txen_d   = 1'b1;
        txd_d    = SFD_BYTE;
        crc_init = 1'b1;
        cnt_d    = '0;
        state_d  = TX_DATA;
      end
      TX_DATA: begin
        txen_d  = 1'b1;
        txd_d   = rd_data_q;
        crc_en  = 1'b1;
        crc_din = rd_data_q;
        rd_addr = ADDR_W'(cnt_q + CNT_W'(1));
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == len_q - CNT_W'(1)) begin
          if (len_q < CNT_W'(MIN_FRAME)) begin
            state_d = TX_PAD;
          end else begin
            state_d = TX_FCS;
            cnt_d   = '0;
          end
        end
      end
      TX_PAD: begin
        txen_d = 1'b1;
        crc_en = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MIN_FRAME - 1)) begin
          state_d = TX_FCS;
          cnt_d   = '0;
        end
      end
      TX_FCS: begin
        txen_d = 1'b1;
        txd_d  = fcs[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(3)) begin
          state_d = TX_IFG;
          cnt_d   = '0;
        end
      end
      TX_IFG: begin
        done_d = (cnt_q == '0);
        cnt_d  = cnt_q + CNT_W'(1);
        // A pending request is taken on the last gap cycle so busy never drops.
        if (cnt_q == CNT_W'(IFG_BYTES - 1)) begin
          cnt_d = '0;
          if (accept) begin
            state_d = TX_PRE;
            len_d   = clamped_len;
          end else begin
            state_d = TX_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Tx_Clk) begin
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      txd_q   <= 8'h00;
      txen_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign PHY_TXD  = txd_q;
  assign PHY_TXEN = txen_q;
  assign Tx_busy  = busy_q;
  assign Tx_done  = done_q;

endmodule

// File: tb/tb_mac_tx2.sv
// Scoreboard bench for mac_tx2: stimulus pushes expected GMII bytes, a monitor pops and compares.
module tb_mac_tx2;

  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned MAX_LEN = 1514;
  localparam int unsigned IFG     = 12;

  logic              Tx_Clk = 1'b0;
  logic              reset;
  logic              Wr_en;
  logic [ADDR_W-1:0] Wr_Addr;
  logic [7:0]        Wr_data;
  logic              Frm_send;
  logic [ADDR_W:0]   Frm_len;
  logic              Tx_busy, Tx_done, PHY_TXEN;
  logic [7:0]        PHY_TXD;

  logic              c_init, c_en;
  logic [7:0]        c_d;
  logic [31:0]       c_out;

  int total = 0;
  int bad   = 0;
  int last_gap = 0;

  logic [7:0] model_mem [0:2047];
  logic [7:0] exp_q [$];
  int         exp_len_q [$];

  always #4 Tx_Clk = ~Tx_Clk;

  mac_tx2 #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN), .IFG_BYTES(IFG)) dut (
    .Tx_Clk   (Tx_Clk),
    .reset    (reset),
    .Wr_en    (Wr_en),
    .Wr_Addr  (Wr_Addr),
    .Wr_data  (Wr_data),
    .Frm_send (Frm_send),
    .Frm_len  (Frm_len),
    .Tx_busy  (Tx_busy),
    .Tx_done  (Tx_done),
    .PHY_TXD  (PHY_TXD),
    .PHY_TXEN (PHY_TXEN)
  );

  crc32_d8 u_crc_chk (
    .clk   (Tx_Clk),
    .reset (reset),
    .init  (c_init),
    .en    (c_en),
    .d     (c_d),
    .crc   (c_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Table-driven reflected CRC-32, register returned without final inversion.
  function automatic logic [31:0] ref_crc(input logic [7:0] b [$]);
    logic [31:0] tbl [0:255];
    logic [31:0] r;
    for (int n = 0; n < 256; n++) begin
      r = 32'(n);
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      tbl[n] = r;
    end
    r = 32'hFFFF_FFFF;
    foreach (b[i]) r = (r >> 8) ^ tbl[r[7:0] ^ b[i]];
    return r;
  endfunction

  task automatic push_frame(input int len_req);
    logic [7:0]  body [$];
    logic [31:0] fcs;
    int          l;
    l = (len_req > int'(MAX_LEN)) ? int'(MAX_LEN) : len_req;
    for (int i = 0; i < l; i++) body.push_back(model_mem[i]);
    while (body.size() < 60) body.push_back(8'h00);
    fcs = ~ref_crc(body);
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
    exp_len_q.push_back(8 + body.size() + 4);
  endtask

  task automatic tick();
    @(posedge Tx_Clk);
    #1;
  endtask

  task automatic write_buf(input int addr, input logic [7:0] val);
    Wr_en = 1'b1; Wr_Addr = ADDR_W'(addr); Wr_data = val;
    tick();
    Wr_en = 1'b0;
    model_mem[addr] = val;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) write_buf(i, 8'($urandom));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && Tx_busy; i++) tick();
    check("busy_timeout", 32'(Tx_busy), 32'd0);
  endtask

  task automatic send(input int len);
    push_frame(len);
    Frm_send = 1'b1; Frm_len = 12'(len);
    tick();
    Frm_send = 1'b0;
    check("busy_on_accept", 32'(Tx_busy), 32'd1);
    check("txen_before", 32'(PHY_TXEN), 32'd0);
    tick();
    check("txen_latency", 32'(PHY_TXEN), 32'd1);
  endtask

  // Monitor: compares every transmitted byte, frame length, done pulse, gap and CRC residue.
  initial begin
    int         run, gap;
    bit         prev, seen;
    logic [7:0] rx [$];
    logic [7:0] e;
    run = 0; gap = 0; prev = 0; seen = 0;
    forever begin
      @(negedge Tx_Clk);
      if (reset) begin
        exp_q.delete(); exp_len_q.delete(); rx.delete();
        run = 0; gap = 0; prev = 0; seen = 0;
      end else if (PHY_TXEN) begin
        if (!prev && seen) begin
          last_gap = gap;
          check("ifg_min", 32'(gap >= int'(IFG)), 32'd1);
        end
        if (exp_q.size() == 0) begin
          check("unexpected_txen", 32'(PHY_TXEN), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("txd", 32'(PHY_TXD), 32'(e));
        end
        if (run >= 8) rx.push_back(PHY_TXD);
        run++; gap = 0; prev = 1;
      end else begin
        check("txd_idle", 32'(PHY_TXD), 32'd0);
        if (prev) begin
          check("done_pulse", 32'(Tx_done), 32'd1);
          if (exp_len_q.size() == 0) check("txen_len_unexpected", 32'(run), 32'd0);
          else check("txen_len", 32'(run), 32'(exp_len_q.pop_front()));
          check("crc_residue", ref_crc(rx), 32'hDEBB_20E3);
          rx.delete(); run = 0; seen = 1;
        end else begin
          check("done_idle", 32'(Tx_done), 32'd0);
        end
        gap++; prev = 0;
      end
    end
  end

  initial begin
    logic [7:0] hdr [0:13];
    string      s;
    logic [31:0] cnt_busy;
    reset = 1'b1; Wr_en = 1'b0; Wr_Addr = '0; Wr_data = '0;
    Frm_send = 1'b0; Frm_len = '0; c_init = 1'b0; c_en = 1'b0; c_d = '0;
    for (int i = 0; i < 2048; i++) model_mem[i] = 8'h00;
    repeat (3) tick();
    check("rst_txd", 32'(PHY_TXD), 32'd0);
    check("rst_txen", 32'(PHY_TXEN), 32'd0);
    check("rst_busy", 32'(Tx_busy), 32'd0);
    check("rst_done", 32'(Tx_done), 32'd0);
    reset = 1'b0;
    tick();

    // CRC unit against the standard check value.
    s = "123456789";
    c_init = 1'b1; tick(); c_init = 1'b0;
    for (int i = 0; i < 9; i++) begin
      c_en = 1'b1; c_d = s[i]; tick();
    end
    c_en = 1'b0;
    check("crc_check_value", ~c_out, 32'hCBF4_3926);

    // L=60, "123456789" then zeros.
    for (int i = 0; i < 60; i++) write_buf(i, (i < 9) ? s[i] : 8'h00);
    send(60); wait_idle();

    // L=64 incrementing.
    for (int i = 0; i < 64; i++) write_buf(i, 8'(i));
    send(64); wait_idle();

    // L=14 header, padded to 60.
    hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h08, 8'h00};
    for (int i = 0; i < 14; i++) write_buf(i, hdr[i]);
    send(14); wait_idle();

    // Back-to-back with Frm_send held high.
    fill_random(60);
    push_frame(60); push_frame(60);
    Frm_send = 1'b1; Frm_len = 12'd60;
    repeat (95) tick();
    Frm_send = 1'b0;
    wait_idle();
    check("b2b_gap", 32'(last_gap), 32'(IFG));

    // Mid-frame request and writes are dropped.
    fill_random(40);
    send(40);
    repeat (20) tick();
    Frm_send = 1'b1; Frm_len = 12'd30;
    for (int i = 0; i < 10; i++) begin
      Wr_en = 1'b1; Wr_Addr = ADDR_W'(i); Wr_data = ~model_mem[i];
      tick();
      Frm_send = 1'b0;
    end
    Wr_en = 1'b0;
    wait_idle();
    send(40); wait_idle();

    // Zero length request is ignored.
    Frm_send = 1'b1; Frm_len = '0;
    tick();
    Frm_send = 1'b0;
    cnt_busy = 0;
    for (int i = 0; i < 30; i++) begin
      if (Tx_busy) cnt_busy++;
      tick();
    end
    check("zero_len_busy", cnt_busy, 32'd0);

    // Random lengths and content.
    for (int f = 0; f < 4; f++) begin
      int l;
      l = int'($urandom_range(1, 200));
      fill_random(l);
      send(l); wait_idle();
    end

    // Reset during DATA byte index 19, then a clean frame.
    fill_random(60);
    send(60);
    repeat (27) tick();
    reset = 1'b1;
    tick();
    check("abort_txen", 32'(PHY_TXEN), 32'd0);
    check("abort_busy", 32'(Tx_busy), 32'd0);
    check("abort_done", 32'(Tx_done), 32'd0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    fill_random(60);
    send(60); wait_idle();

    // Maximum length and clamped over-length request.
    fill_random(int'(MAX_LEN));
    send(int'(MAX_LEN)); wait_idle();
    send(2000); wait_idle();

    repeat (20) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("len_queue_empty", 32'(exp_len_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
